// File: rtl/inst_sram_ctrl_pkg.sv
// Shared types and polarity constants for the instruction SRAM controller.
// Included by the controller via import inst_sram_ctrl_pkg::*.
package inst_sram_ctrl_pkg;

  localparam int INST_BUS_W  = 32;
  localparam int INST_ADDR_W = 32;

  localparam logic RST_ENABLE   = 1'b1;
  localparam logic TRUE_V       = 1'b1;
  localparam logic FALSE_V      = 1'b0;
  localparam logic CHIP_ENABLE  = 1'b0;
  localparam logic CHIP_DISABLE = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

endpackage

// File: rtl/inst_sram_ctrl.sv
// Instruction-fetch responder for an asynchronous 32-bit SRAM with a
// wait-stated read cycle and a one-entry last-word buffer.
module inst_sram_ctrl
  import inst_sram_ctrl_pkg::*;
#(
  parameter int          WAIT_CYCLES = 2,
  parameter int          ADDR_W      = 20,
  parameter logic [31:0] NOP_INST    = 32'h0000_0000
) (
  input  logic                   cpu_clk_50M,
  input  logic                   cpu_rst,
  input  logic                   ice,
  input  logic [INST_ADDR_W-1:0] iaddr,
  input  logic                   flush,
  output logic [INST_BUS_W-1:0]  inst,
  output logic                   inst_valid,
  output logic                   stallreq_if,
  output logic [ADDR_W-1:0]      sram_addr,
  output logic                   sram_ce_n,
  output logic                   sram_oe_n,
  output logic                   sram_we_n,
  output logic [3:0]             sram_be_n,
  input  logic [INST_BUS_W-1:0]  sram_data
);

  localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

  state_t                  state;
  state_t                  state_nx;
  logic [3:0]              wait_cnt;
  logic                    buf_valid;
  logic [ADDR_W-1:0]       buf_addr;
  logic [INST_BUS_W-1:0]   buf_data;
  logic [ADDR_W-1:0]       word;
  logic                    hit;
  logic                    last;
  logic                    unused_iaddr;

  assign word = iaddr[ADDR_W+1:2];
  assign hit  = buf_valid && (buf_addr == word);
  assign last = (wait_cnt == LAST_CNT);

  assign unused_iaddr = ^{iaddr[INST_ADDR_W-1:ADDR_W+2], iaddr[1:0]};

  assign sram_oe_n = sram_ce_n;
  assign sram_we_n = TRUE_V;
  assign sram_be_n = 4'b0000;

  always_comb begin
    state_nx    = state;
    stallreq_if = FALSE_V;
    inst_valid  = FALSE_V;
    unique case (state)
      IDLE: begin
        if (ice && !flush) begin
          stallreq_if = TRUE_V;
          state_nx    = hit ? RESP : ACCESS;
        end
      end
      ACCESS: begin
        stallreq_if = TRUE_V;
        if (flush) begin
          state_nx = IDLE;
        end else if (last) begin
          state_nx = RESP;
        end
      end
      RESP: begin
        inst_valid = !flush;
        state_nx   = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge cpu_clk_50M) begin
    if (cpu_rst == RST_ENABLE) begin
      state     <= IDLE;
      sram_ce_n <= CHIP_DISABLE;
      sram_addr <= '0;
      wait_cnt  <= 4'd0;
      inst      <= NOP_INST;
      buf_valid <= FALSE_V;
      buf_addr  <= '0;
      buf_data  <= '0;
    end else begin
      state <= state_nx;
      unique case (state)
        IDLE: begin
          if (ice && !flush) begin
            if (hit) begin
              inst <= buf_data;
            end else begin
              sram_addr <= word;
              sram_ce_n <= CHIP_ENABLE;
              wait_cnt  <= 4'd0;
            end
          end
        end
        ACCESS: begin
          // abort leaves the buffer untouched; flush beats completion
          if (flush) begin
            sram_ce_n <= CHIP_DISABLE;
          end else if (last) begin
            inst      <= sram_data;
            buf_data  <= sram_data;
            buf_addr  <= sram_addr;
            buf_valid <= TRUE_V;
            sram_ce_n <= CHIP_DISABLE;
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_sram_ctrl.sv
// Scoreboard bench for inst_sram_ctrl: directed cases plus random fetches
// checked against a last-word buffer model and a behavioural SRAM.
module tb_inst_sram_ctrl;

  localparam int W  = 2;
  localparam int AW = 20;

  typedef struct {
    logic [31:0] d;
    int          c;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          ice;
  logic          flush;
  logic [31:0]   iaddr;
  logic [31:0]   inst;
  logic          inst_valid;
  logic          stallreq_if;
  logic [AW-1:0] sram_addr;
  logic          ce_n;
  logic          oe_n;
  logic          we_n;
  logic [3:0]    be_n;
  logic [31:0]   sram_data;

  logic [31:0]   mem [logic [AW-1:0]];
  exp_t          q [$];
  bit            bv;
  logic [AW-1:0] ba;
  int            errors = 0;
  int            checks = 0;
  int            cyc = 0;

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  inst_sram_ctrl #(
    .WAIT_CYCLES(W),
    .ADDR_W     (AW),
    .NOP_INST   (32'h0000_0000)
  ) dut (
    .cpu_clk_50M(clk),
    .cpu_rst    (rst),
    .ice        (ice),
    .iaddr      (iaddr),
    .flush      (flush),
    .inst       (inst),
    .inst_valid (inst_valid),
    .stallreq_if(stallreq_if),
    .sram_addr  (sram_addr),
    .sram_ce_n  (ce_n),
    .sram_oe_n  (oe_n),
    .sram_we_n  (we_n),
    .sram_be_n  (be_n),
    .sram_data  (sram_data)
  );

  function automatic logic [31:0] memval(input logic [AW-1:0] a);
    if (mem.exists(a)) return mem[a];
    return 32'h5A00_0000 ^ {a, a[11:0]};
  endfunction

  always_comb begin
    sram_data = 32'hBAD0_0BAD;
    if (!ce_n && !oe_n) sram_data = memval(sram_addr);
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  task automatic monitor_loop();
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && inst_valid) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_valid: got inst=%h at cycle %0d expected no response",
                   inst, cyc);
        end else begin
          e = q.pop_front();
          chk("inst_data", inst, e.d);
          chk("valid_cycle", cyc, e.c);
        end
      end
    end
  endtask

  task automatic idle(input int k);
    ice   = 1'b0;
    flush = 1'b0;
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  // fc: cycle of the fetch (1 = accept cycle) in which flush is raised, 0 = none
  task automatic fetch(input logic [31:0] a, input int fc, input bit rnd);
    logic [AW-1:0] w;
    bit            hit;
    bit            abort;
    bit            resp;
    int            total;
    int            n;
    int            start;
    int            stall_n;
    int            ce_cnt;
    int            exp_stall;
    int            exp_ce;
    exp_t          e;
    w       = a[AW+1:2];
    hit     = bv && (ba == w);
    total   = hit ? 2 : W + 2;
    abort   = !hit && fc >= 2 && fc <= W + 1;
    start   = cyc;
    stall_n = 0;
    ce_cnt  = 0;
    if (fc == 1) begin
      n = 1; resp = 0; exp_stall = 0; exp_ce = 0;
    end else if (abort) begin
      n = fc; resp = 0; exp_stall = fc; exp_ce = fc - 1;
    end else begin
      n = total; resp = (fc != total);
      exp_stall = hit ? 1 : W + 1;
      exp_ce    = hit ? 0 : W;
    end
    if (resp) begin
      e.d = memval(w);
      e.c = start + total - 1;
      q.push_back(e);
    end
    if (!hit && fc != 1 && !abort) begin
      bv = 1'b1;
      ba = w;
    end
    for (int i = 1; i <= n; i++) begin
      ice   = (i == 1) ? 1'b1 : (rnd ? 1'($urandom) : 1'b0);
      iaddr = (i == 1 || !rnd) ? a : $urandom;
      flush = (i == fc);
      @(negedge clk);
      stall_n += int'(stallreq_if);
      if (!ce_n) begin
        ce_cnt++;
        chk("sram_addr", 32'(sram_addr), 32'(w));
      end
      @(posedge clk);
      #1;
    end
    ice   = 1'b0;
    flush = 1'b0;
    chk("stall_cycles", stall_n, exp_stall);
    chk("ce_low_cycles", ce_cnt, exp_ce);
  endtask

  task automatic reset_mid(input logic [31:0] a);
    ice   = 1'b1;
    iaddr = a;
    flush = 1'b0;
    @(posedge clk);
    #1;
    ice = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    bv  = 1'b0;
    @(negedge clk);
    chk("rst_mid_ce_n", ce_n, 1'b1);
    chk("rst_mid_stall", stallreq_if, 1'b0);
    chk("rst_mid_inst", inst, 32'h0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] last_a;
    int          fc;
    fork
      monitor_loop();
    join_none
    rst   = 1'b1;
    ice   = 1'b0;
    flush = 1'b0;
    iaddr = 32'h0;
    bv    = 1'b0;
    ba    = '0;
    mem[20'h00000] = 32'h3C08_1234;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_inst", inst, 32'h0);
    chk("rst_valid", inst_valid, 1'b0);
    chk("rst_ce_n", ce_n, 1'b1);
    chk("rst_oe_n", oe_n, 1'b1);
    chk("rst_stall", stallreq_if, 1'b0);
    chk("rst_sram_addr", 32'(sram_addr), 32'h0);
    chk("we_n", we_n, 1'b1);
    chk("be_n", 32'(be_n), 32'h0);
    @(posedge clk);
    #1;

    fetch(32'hBFC0_0000, 0, 0);
    idle(1);
    fetch(32'hBFC0_0000, 0, 0);
    fetch(32'hBFC0_0100, 3, 0);
    fetch(32'hBFC0_0100, 0, 0);
    fetch(32'hBFC0_0200, W + 2, 0);
    fetch(32'hBFC0_0200, 0, 0);
    fetch(32'hBFC0_0300, 1, 0);
    fetch(32'hBFC0_0204, W + 1, 0);
    reset_mid(32'hBFC0_0400);
    fetch(32'hBFC0_0000, 0, 0);

    last_a = 32'hBFC0_0000;
    for (int t = 0; t < 300; t++) begin
      if ($urandom_range(1, 2) == 1) begin
        a = {$urandom_range(0, 1023), last_a[21:0]};
      end else begin
        a = {$urandom_range(0, 1023), 17'h0, 3'($urandom_range(0, 7)), 2'($urandom)};
      end
      fc = ($urandom_range(0, 9) < 6) ? 0 : $urandom_range(1, W + 2);
      fetch(a, fc, 1);
      last_a = a;
      idle($urandom_range(0, 2));
    end

    idle(3);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL missing_responses: got %0d outstanding expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
